// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: opcodes, ALU ops, fixed registers and status codes.
package wb_pkg;

    localparam logic [4:0] OP_ALU_R = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [4:0] REG_STATUS = 5'd30;
    localparam logic [4:0] REG_LINK   = 5'd31;

    localparam logic [31:0] STATUS_MUL = 32'd4;
    localparam logic [31:0] STATUS_DIV = 32'd5;

    typedef enum logic {
        SEL_ALU = 1'b0,
        SEL_MEM = 1'b1
    } wb_sel_e;

    typedef enum logic {
        PEND_EMPTY = 1'b0,
        PEND_FULL  = 1'b1
    } pend_state_e;

endpackage

// File: rtl/wb_decode.sv
// Writeback decode: which register (if any) the latched instruction writes and from which source.
module wb_decode
    import wb_pkg::*;
(
    input  logic [31:0] in_ir,
    output logic        has_write,
    output logic [4:0]  dest,
    output wb_sel_e     data_sel
);

    logic [4:0] opcode;
    logic [4:0] alu_op;
    logic [4:0] rd;
    logic       raw_write;
    logic       unused_ir_bits;

    assign opcode         = in_ir[31:27];
    assign rd             = in_ir[26:22];
    assign alu_op         = in_ir[6:2];
    assign unused_ir_bits = ^{in_ir[21:7], in_ir[1:0]};

    always_comb begin
        raw_write = 1'b0;
        dest      = REG_ZERO;
        data_sel  = SEL_ALU;
        case (opcode)
            OP_ALU_R: begin
                // mul/div retire later through the pending buffer
                if (alu_op != ALU_MUL && alu_op != ALU_DIV) begin
                    raw_write = 1'b1;
                    dest      = rd;
                end
            end
            OP_ADDI: begin
                raw_write = 1'b1;
                dest      = rd;
            end
            OP_LW: begin
                raw_write = 1'b1;
                dest      = rd;
                data_sel  = SEL_MEM;
            end
            OP_JAL: begin
                raw_write = 1'b1;
                dest      = REG_LINK;
            end
            OP_SETX: begin
                raw_write = 1'b1;
                dest      = REG_STATUS;
            end
            default: begin
                raw_write = 1'b0;
            end
        endcase
    end

    assign has_write = raw_write && (dest != REG_ZERO);

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: regfile write-port arbitration between the in-order pipeline and a
// one-entry pending buffer holding multiplier/divider results.
module wb_stage
    import wb_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_ir,
    input  logic [31:0] in_O,
    input  logic [31:0] in_D,
    input  logic        md_ready,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_is_div,
    input  logic [4:0]  md_rd,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic        pend_valid,
    output logic [4:0]  pend_reg,
    output logic [31:0] pend_data,
    output logic        stall_req
);

    logic        pipe_write;
    logic [4:0]  pipe_dest;
    wb_sel_e     pipe_sel;
    logic [31:0] pipe_data;

    logic [4:0]  cap_reg;
    logic [31:0] cap_data;
    logic        capture;
    logic        drain;
    logic        discard;

    pend_state_e state_q, state_d;
    logic [4:0]  pend_reg_q, pend_reg_d;
    logic [31:0] pend_data_q, pend_data_d;

    wb_decode u_decode (
        .in_ir     (in_ir),
        .has_write (pipe_write),
        .dest      (pipe_dest),
        .data_sel  (pipe_sel)
    );

    assign pipe_data = (pipe_sel == SEL_MEM) ? in_D : in_O;

    always_comb begin
        cap_reg  = md_rd;
        cap_data = md_result;
        if (md_exception) begin
            cap_reg  = REG_STATUS;
            cap_data = md_is_div ? STATUS_DIV : STATUS_MUL;
        end
    end

    assign capture = md_ready && (cap_reg != REG_ZERO);
    assign drain   = (state_q == PEND_FULL) && !pipe_write;
    // A younger pipeline write to the same register makes the buffered value dead.
    assign discard = (state_q == PEND_FULL) && pipe_write && (pipe_dest == pend_reg_q);

    always_comb begin
        state_d     = state_q;
        pend_reg_d  = pend_reg_q;
        pend_data_d = pend_data_q;
        case (state_q)
            PEND_EMPTY: begin
                if (capture) begin
                    state_d     = PEND_FULL;
                    pend_reg_d  = cap_reg;
                    pend_data_d = cap_data;
                end
            end
            PEND_FULL: begin
                // A new capture always wins; if the old entry could not leave it is overwritten.
                if (capture) begin
                    state_d     = PEND_FULL;
                    pend_reg_d  = cap_reg;
                    pend_data_d = cap_data;
                end else if (drain || discard) begin
                    state_d     = PEND_EMPTY;
                    pend_reg_d  = REG_ZERO;
                    pend_data_d = 32'd0;
                end
            end
            default: begin
                state_d = PEND_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= PEND_EMPTY;
            pend_reg_q  <= REG_ZERO;
            pend_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pend_reg_q  <= pend_reg_d;
            pend_data_q <= pend_data_d;
        end
    end

    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = REG_ZERO;
        data_writeReg    = 32'd0;
        if (pipe_write) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = pipe_dest;
            data_writeReg    = pipe_data;
        end else if (state_q == PEND_FULL) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = pend_reg_q;
            data_writeReg    = pend_data_q;
        end
    end

    assign pend_valid = (state_q == PEND_FULL);
    assign pend_reg   = pend_reg_q;
    assign pend_data  = pend_data_q;
    assign stall_req  = (state_q == PEND_FULL) && pipe_write && (pipe_dest != pend_reg_q);

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by randomized traffic
// against a register-write reference model.
module tb_wb_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_ir, in_O, in_D;
    logic        md_ready;
    logic [31:0] md_result;
    logic        md_exception, md_is_div;
    logic [4:0]  md_rd;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        pend_valid;
    logic [4:0]  pend_reg;
    logic [31:0] pend_data;
    logic        stall_req;

    int checks = 0;
    int failures = 0;

    // Reference model of the pending result
    bit          m_valid = 0;
    logic [4:0]  m_reg = 0;
    logic [31:0] m_data = 0;

    wb_stage dut (
        .clock            (clock),
        .reset            (reset),
        .in_ir            (in_ir),
        .in_O             (in_O),
        .in_D             (in_D),
        .md_ready         (md_ready),
        .md_result        (md_result),
        .md_exception     (md_exception),
        .md_is_div        (md_is_div),
        .md_rd            (md_rd),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .pend_valid       (pend_valid),
        .pend_reg         (pend_reg),
        .pend_data        (pend_data),
        .stall_req        (stall_req)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] aluop);
        return {5'b00000, rd, 15'd0, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] mk_i(input logic [4:0] op, input logic [4:0] rd);
        return {op, rd, 22'd0};
    endfunction

    // Which architectural register the instruction writes, and with what value.
    function automatic void pipe_model(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] d,
                                       output bit has, output logic [4:0] dst, output logic [31:0] val);
        logic [4:0] op;
        logic [4:0] fn;
        op  = ir[31:27];
        fn  = ir[6:2];
        has = 0;
        dst = 0;
        val = 0;
        if (op == 5'd0 && fn != 5'd6 && fn != 5'd7) begin has = 1; dst = ir[26:22]; val = o; end
        else if (op == 5'd5)  begin has = 1; dst = ir[26:22]; val = o; end
        else if (op == 5'd8)  begin has = 1; dst = ir[26:22]; val = d; end
        else if (op == 5'd3)  begin has = 1; dst = 5'd31;     val = o; end
        else if (op == 5'd21) begin has = 1; dst = 5'd30;     val = o; end
        if (dst == 5'd0) has = 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] d,
                         input logic mr, input logic [31:0] res, input logic exc, input logic dv,
                         input logic [4:0] rd);
        in_ir = ir; in_O = o; in_D = d;
        md_ready = mr; md_result = res; md_exception = exc; md_is_div = dv; md_rd = rd;
    endtask

    // Called one time unit after a rising edge with inputs already applied.
    task automatic cycle(input string tag);
        bit          has;
        logic [4:0]  dst;
        logic [31:0] val;
        logic        ew;
        logic [4:0]  er;
        logic [31:0] ed;
        logic        es;
        logic [4:0]  cr;
        logic [31:0] cd;
        #3;
        pipe_model(in_ir, in_O, in_D, has, dst, val);
        if (has)          begin ew = 1; er = dst;   ed = val;    end
        else if (m_valid) begin ew = 1; er = m_reg; ed = m_data; end
        else              begin ew = 0; er = 0;     ed = 0;      end
        es = m_valid && has && (dst != m_reg);
        chk({tag, "_we"},    {31'd0, ctrl_writeEnable}, {31'd0, ew});
        chk({tag, "_wreg"},  {27'd0, ctrl_writeReg},    {27'd0, er});
        chk({tag, "_wdata"}, data_writeReg,             ed);
        chk({tag, "_stall"}, {31'd0, stall_req},        {31'd0, es});
        @(posedge clock);
        if (m_valid && (!has || dst == m_reg)) m_valid = 0;
        if (md_ready) begin
            cr = md_exception ? 5'd30 : md_rd;
            cd = md_exception ? (md_is_div ? 32'd5 : 32'd4) : md_result;
            if (cr != 0) begin m_valid = 1; m_reg = cr; m_data = cd; end
        end
        #1;
        chk({tag, "_pv"}, {31'd0, pend_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk({tag, "_preg"},  {27'd0, pend_reg}, {27'd0, m_reg});
            chk({tag, "_pdata"}, pend_data,         m_data);
        end
    endtask

    initial begin
        bit          has;
        logic [4:0]  dst;
        logic [31:0] val;
        logic [31:0] ir;
        bit          ok;
        int          k;

        reset = 1'b1;
        drive(32'd0, 32'd0, 32'd0, 0, 32'd0, 0, 0, 5'd0);
        #2;
        chk("rst_pv",    {31'd0, pend_valid},       32'd0);
        chk("rst_preg",  {27'd0, pend_reg},         32'd0);
        chk("rst_pdata", pend_data,                 32'd0);
        chk("rst_stall", {31'd0, stall_req},        32'd0);
        chk("rst_we",    {31'd0, ctrl_writeEnable}, 32'd0);
        #2 reset = 1'b0;
        @(posedge clock); #1;

        drive(mk_i(5'd5, 5'd5), 32'h1234, 32'h0, 0, 0, 0, 0, 0);     cycle("addi5");
        drive(mk_i(5'd8, 5'd7), 32'h0, 32'hBEEF, 0, 0, 0, 0, 0);     cycle("lw7");
        drive(mk_i(5'd7, 5'd7), 32'h77, 32'h88, 0, 0, 0, 0, 0);      cycle("sw");
        drive(mk_r(5'd0, 5'd0), 32'h99, 32'h0, 0, 0, 0, 0, 0);       cycle("add_r0");
        drive(mk_r(5'd4, 5'd6), 32'h99, 32'h0, 0, 0, 0, 0, 0);       cycle("mul_r");
        drive(mk_i(5'd3, 5'd0), 32'h100, 32'h0, 0, 0, 0, 0, 0);      cycle("jal");
        drive(mk_i(5'd21, 5'd0), 32'h55, 32'h0, 0, 0, 0, 0, 0);      cycle("setx");

        drive(32'd0, 0, 0, 1, 32'd42, 0, 0, 5'd9);                   cycle("md_cap");
        drive(32'd0, 0, 0, 0, 0, 0, 0, 0);                           cycle("md_drain");

        drive(32'd0, 0, 0, 1, 32'd42, 0, 0, 5'd9);                   cycle("md_cap2");
        drive(mk_i(5'd5, 5'd3), 32'h33, 0, 0, 0, 0, 0, 0);           cycle("stall_addi3");
        drive(32'd0, 0, 0, 0, 0, 0, 0, 0);                           cycle("bubble_drain");

        drive(32'd0, 0, 0, 1, 32'd42, 0, 0, 5'd9);                   cycle("md_cap3");
        drive(mk_i(5'd5, 5'd9), 32'd7, 0, 0, 0, 0, 0, 0);            cycle("waw9");
        drive(32'd0, 0, 0, 0, 0, 0, 0, 0);                           cycle("after_waw");

        drive(32'd0, 0, 0, 1, 32'd123, 1, 1, 5'd12);                 cycle("div_exc");
        drive(32'd0, 0, 0, 0, 0, 0, 0, 0);                           cycle("div_exc_wr");
        drive(32'd0, 0, 0, 1, 32'd123, 1, 0, 5'd12);                 cycle("mul_exc");
        drive(32'd0, 0, 0, 0, 0, 0, 0, 0);                           cycle("mul_exc_wr");
        drive(32'd0, 0, 0, 1, 32'd55, 0, 0, 5'd0);                   cycle("md_r0");

        drive(32'd0, 0, 0, 1, 32'd42, 0, 0, 5'd9);                   cycle("md_cap4");
        drive(32'd0, 0, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_pv",    {31'd0, pend_valid},       32'd0);
        chk("arst_preg",  {27'd0, pend_reg},         32'd0);
        chk("arst_pdata", pend_data,                 32'd0);
        chk("arst_we",    {31'd0, ctrl_writeEnable}, 32'd0);
        m_valid = 0; m_reg = 0; m_data = 0;
        #2 reset = 1'b0;
        @(posedge clock); #1;
        drive(32'd0, 0, 0, 0, 0, 0, 0, 0);                           cycle("post_rst");

        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 7);
            case (k)
                0: ir = 32'd0;
                1: ir = mk_r(5'($urandom_range(0, 7)), 5'd0);
                2: ir = mk_r(5'($urandom_range(0, 7)), 5'($urandom_range(6, 7)));
                3: ir = mk_i(5'd5, 5'($urandom_range(0, 7)));
                4: ir = mk_i(5'd8, 5'($urandom_range(0, 7)));
                5: ir = mk_i(5'd3, 5'd0);
                6: ir = mk_i(5'd21, 5'd0);
                default: ir = mk_i(5'd7, 5'($urandom_range(0, 7)));
            endcase
            in_O = $urandom; in_D = $urandom;
            pipe_model(ir, in_O, in_D, has, dst, val);
            ok = !m_valid || !has || (dst == m_reg);
            in_ir        = ir;
            md_ready     = ok && ($urandom_range(0, 2) == 0);
            md_result    = $urandom;
            md_exception = ($urandom_range(0, 5) == 0);
            md_is_div    = $urandom_range(0, 1);
            md_rd        = 5'($urandom_range(0, 31) < 24 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
